// File: rtl/riscvsys_pkg.sv
// Shared types for the riscvsys instruction event monitor.
// Event index order matches the core's decoded-instruction flag list.
package riscvsys_pkg;

   localparam int NUM_EV = 49;

   typedef enum logic [5:0] {
      EV_LUI          = 6'd0,
      EV_AUIPC        = 6'd1,
      EV_JAL          = 6'd2,
      EV_JALR         = 6'd3,
      EV_BEQ          = 6'd4,
      EV_BNE          = 6'd5,
      EV_BLT          = 6'd6,
      EV_BGE          = 6'd7,
      EV_BLTU         = 6'd8,
      EV_BGEU         = 6'd9,
      EV_LB           = 6'd10,
      EV_LH           = 6'd11,
      EV_LW           = 6'd12,
      EV_LBU          = 6'd13,
      EV_LHU          = 6'd14,
      EV_SB           = 6'd15,
      EV_SH           = 6'd16,
      EV_SW           = 6'd17,
      EV_ADDI         = 6'd18,
      EV_SLTI         = 6'd19,
      EV_SLTIU        = 6'd20,
      EV_XORI         = 6'd21,
      EV_ORI          = 6'd22,
      EV_ANDI         = 6'd23,
      EV_SLLI         = 6'd24,
      EV_SRLI         = 6'd25,
      EV_SRAI         = 6'd26,
      EV_ADD          = 6'd27,
      EV_SUB          = 6'd28,
      EV_SLL          = 6'd29,
      EV_SLT          = 6'd30,
      EV_SLTU         = 6'd31,
      EV_XOR          = 6'd32,
      EV_SRL          = 6'd33,
      EV_SRA          = 6'd34,
      EV_OR           = 6'd35,
      EV_AND          = 6'd36,
      EV_RDCYCLE      = 6'd37,
      EV_RDCYCLEH     = 6'd38,
      EV_RDINSTR      = 6'd39,
      EV_RDINSTRH     = 6'd40,
      EV_ECALL_EBREAK = 6'd41,
      EV_GETQ         = 6'd42,
      EV_SETQ         = 6'd43,
      EV_RETIRQ       = 6'd44,
      EV_MASKIRQ      = 6'd45,
      EV_WAITIRQ      = 6'd46,
      EV_TIMER        = 6'd47,
      EV_TRAP         = 6'd48
   } ev_idx_e;

   typedef logic [NUM_EV-1:0] ev_vec_t;

endpackage

// File: rtl/riscvsys_evmon.sv
// Instruction event monitor: one registered pulse per decoded instruction class on each launch.
// Latency 1 cycle, one pulse per i_dbg_next cycle; no handshake and no backpressure.
module riscvsys_evmon
   import riscvsys_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_instr_lui,
   input  logic            i_instr_auipc,
   input  logic            i_instr_jal,
   input  logic            i_instr_jalr,
   input  logic            i_instr_beq,
   input  logic            i_instr_bne,
   input  logic            i_instr_blt,
   input  logic            i_instr_bge,
   input  logic            i_instr_bltu,
   input  logic            i_instr_bgeu,
   input  logic            i_instr_lb,
   input  logic            i_instr_lh,
   input  logic            i_instr_lw,
   input  logic            i_instr_lbu,
   input  logic            i_instr_lhu,
   input  logic            i_instr_sb,
   input  logic            i_instr_sh,
   input  logic            i_instr_sw,
   input  logic            i_instr_addi,
   input  logic            i_instr_slti,
   input  logic            i_instr_sltiu,
   input  logic            i_instr_xori,
   input  logic            i_instr_ori,
   input  logic            i_instr_andi,
   input  logic            i_instr_slli,
   input  logic            i_instr_srli,
   input  logic            i_instr_srai,
   input  logic            i_instr_add,
   input  logic            i_instr_sub,
   input  logic            i_instr_sll,
   input  logic            i_instr_slt,
   input  logic            i_instr_sltu,
   input  logic            i_instr_xor,
   input  logic            i_instr_srl,
   input  logic            i_instr_sra,
   input  logic            i_instr_or,
   input  logic            i_instr_and,
   input  logic            i_instr_rdcycle,
   input  logic            i_instr_rdcycleh,
   input  logic            i_instr_rdinstr,
   input  logic            i_instr_rdinstrh,
   input  logic            i_instr_ecall_ebreak,
   input  logic            i_instr_getq,
   input  logic            i_instr_setq,
   input  logic            i_instr_retirq,
   input  logic            i_instr_maskirq,
   input  logic            i_instr_waitirq,
   input  logic            i_instr_timer,
   input  logic            i_instr_trap,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_next_pc,
   input  logic            i_dbg_next,
   output logic            ev_lui,
   output logic            ev_auipc,
   output logic            ev_jal,
   output logic            ev_jalr,
   output logic            ev_beq,
   output logic            ev_bne,
   output logic            ev_blt,
   output logic            ev_bge,
   output logic            ev_bltu,
   output logic            ev_bgeu,
   output logic            ev_lb,
   output logic            ev_lh,
   output logic            ev_lw,
   output logic            ev_lbu,
   output logic            ev_lhu,
   output logic            ev_sb,
   output logic            ev_sh,
   output logic            ev_sw,
   output logic            ev_addi,
   output logic            ev_slti,
   output logic            ev_sltiu,
   output logic            ev_xori,
   output logic            ev_ori,
   output logic            ev_andi,
   output logic            ev_slli,
   output logic            ev_srli,
   output logic            ev_srai,
   output logic            ev_add,
   output logic            ev_sub,
   output logic            ev_sll,
   output logic            ev_slt,
   output logic            ev_sltu,
   output logic            ev_xor,
   output logic            ev_srl,
   output logic            ev_sra,
   output logic            ev_or,
   output logic            ev_and,
   output logic            ev_rdcycle,
   output logic            ev_rdcycleh,
   output logic            ev_rdinstr,
   output logic            ev_rdinstrh,
   output logic            ev_ecall_ebreak,
   output logic            ev_getq,
   output logic            ev_setq,
   output logic            ev_retirq,
   output logic            ev_maskirq,
   output logic            ev_waitirq,
   output logic            ev_timer,
   output logic            ev_trap,
   output logic            ev_valid,
   output logic [XLEN-1:0] ev_pc,
   output logic [XLEN-1:0] ev_next_pc
);

   ev_vec_t         w_flags;
   ev_vec_t         w_ev_d;
   ev_vec_t         r_ev;
   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_next_pc;

   always_comb begin
      w_flags                  = '0;
      w_flags[EV_LUI]          = i_instr_lui;
      w_flags[EV_AUIPC]        = i_instr_auipc;
      w_flags[EV_JAL]          = i_instr_jal;
      w_flags[EV_JALR]         = i_instr_jalr;
      w_flags[EV_BEQ]          = i_instr_beq;
      w_flags[EV_BNE]          = i_instr_bne;
      w_flags[EV_BLT]          = i_instr_blt;
      w_flags[EV_BGE]          = i_instr_bge;
      w_flags[EV_BLTU]         = i_instr_bltu;
      w_flags[EV_BGEU]         = i_instr_bgeu;
      w_flags[EV_LB]           = i_instr_lb;
      w_flags[EV_LH]           = i_instr_lh;
      w_flags[EV_LW]           = i_instr_lw;
      w_flags[EV_LBU]          = i_instr_lbu;
      w_flags[EV_LHU]          = i_instr_lhu;
      w_flags[EV_SB]           = i_instr_sb;
      w_flags[EV_SH]           = i_instr_sh;
      w_flags[EV_SW]           = i_instr_sw;
      w_flags[EV_ADDI]         = i_instr_addi;
      w_flags[EV_SLTI]         = i_instr_slti;
      w_flags[EV_SLTIU]        = i_instr_sltiu;
      w_flags[EV_XORI]         = i_instr_xori;
      w_flags[EV_ORI]          = i_instr_ori;
      w_flags[EV_ANDI]         = i_instr_andi;
      w_flags[EV_SLLI]         = i_instr_slli;
      w_flags[EV_SRLI]         = i_instr_srli;
      w_flags[EV_SRAI]         = i_instr_srai;
      w_flags[EV_ADD]          = i_instr_add;
      w_flags[EV_SUB]          = i_instr_sub;
      w_flags[EV_SLL]          = i_instr_sll;
      w_flags[EV_SLT]          = i_instr_slt;
      w_flags[EV_SLTU]         = i_instr_sltu;
      w_flags[EV_XOR]          = i_instr_xor;
      w_flags[EV_SRL]          = i_instr_srl;
      w_flags[EV_SRA]          = i_instr_sra;
      w_flags[EV_OR]           = i_instr_or;
      w_flags[EV_AND]          = i_instr_and;
      w_flags[EV_RDCYCLE]      = i_instr_rdcycle;
      w_flags[EV_RDCYCLEH]     = i_instr_rdcycleh;
      w_flags[EV_RDINSTR]      = i_instr_rdinstr;
      w_flags[EV_RDINSTRH]     = i_instr_rdinstrh;
      w_flags[EV_ECALL_EBREAK] = i_instr_ecall_ebreak;
      w_flags[EV_GETQ]         = i_instr_getq;
      w_flags[EV_SETQ]         = i_instr_setq;
      w_flags[EV_RETIRQ]       = i_instr_retirq;
      w_flags[EV_MASKIRQ]      = i_instr_maskirq;
      w_flags[EV_WAITIRQ]      = i_instr_waitirq;
      w_flags[EV_TIMER]        = i_instr_timer;
      w_flags[EV_TRAP]         = i_instr_trap;
   end

   // AND-gating keeps undriven/X flags out of the event flops when no launch is happening
   assign w_ev_d = w_flags & {NUM_EV{i_dbg_next}};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ev    <= '0;
         r_valid <= 1'b0;
      end else begin
         r_ev    <= w_ev_d;
         r_valid <= |w_ev_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc      <= '0;
         r_next_pc <= '0;
      end else if (i_dbg_next) begin
         r_pc      <= i_pc;
         r_next_pc <= i_next_pc;
      end
   end

   assign ev_lui          = r_ev[EV_LUI];
   assign ev_auipc        = r_ev[EV_AUIPC];
   assign ev_jal          = r_ev[EV_JAL];
   assign ev_jalr         = r_ev[EV_JALR];
   assign ev_beq          = r_ev[EV_BEQ];
   assign ev_bne          = r_ev[EV_BNE];
   assign ev_blt          = r_ev[EV_BLT];
   assign ev_bge          = r_ev[EV_BGE];
   assign ev_bltu         = r_ev[EV_BLTU];
   assign ev_bgeu         = r_ev[EV_BGEU];
   assign ev_lb           = r_ev[EV_LB];
   assign ev_lh           = r_ev[EV_LH];
   assign ev_lw           = r_ev[EV_LW];
   assign ev_lbu          = r_ev[EV_LBU];
   assign ev_lhu          = r_ev[EV_LHU];
   assign ev_sb           = r_ev[EV_SB];
   assign ev_sh           = r_ev[EV_SH];
   assign ev_sw           = r_ev[EV_SW];
   assign ev_addi         = r_ev[EV_ADDI];
   assign ev_slti         = r_ev[EV_SLTI];
   assign ev_sltiu        = r_ev[EV_SLTIU];
   assign ev_xori         = r_ev[EV_XORI];
   assign ev_ori          = r_ev[EV_ORI];
   assign ev_andi         = r_ev[EV_ANDI];
   assign ev_slli         = r_ev[EV_SLLI];
   assign ev_srli         = r_ev[EV_SRLI];
   assign ev_srai         = r_ev[EV_SRAI];
   assign ev_add          = r_ev[EV_ADD];
   assign ev_sub          = r_ev[EV_SUB];
   assign ev_sll          = r_ev[EV_SLL];
   assign ev_slt          = r_ev[EV_SLT];
   assign ev_sltu         = r_ev[EV_SLTU];
   assign ev_xor          = r_ev[EV_XOR];
   assign ev_srl          = r_ev[EV_SRL];
   assign ev_sra          = r_ev[EV_SRA];
   assign ev_or           = r_ev[EV_OR];
   assign ev_and          = r_ev[EV_AND];
   assign ev_rdcycle      = r_ev[EV_RDCYCLE];
   assign ev_rdcycleh     = r_ev[EV_RDCYCLEH];
   assign ev_rdinstr      = r_ev[EV_RDINSTR];
   assign ev_rdinstrh     = r_ev[EV_RDINSTRH];
   assign ev_ecall_ebreak = r_ev[EV_ECALL_EBREAK];
   assign ev_getq         = r_ev[EV_GETQ];
   assign ev_setq         = r_ev[EV_SETQ];
   assign ev_retirq       = r_ev[EV_RETIRQ];
   assign ev_maskirq      = r_ev[EV_MASKIRQ];
   assign ev_waitirq      = r_ev[EV_WAITIRQ];
   assign ev_timer        = r_ev[EV_TIMER];
   assign ev_trap         = r_ev[EV_TRAP];
   assign ev_valid        = r_valid;
   assign ev_pc           = r_pc;
   assign ev_next_pc      = r_next_pc;

endmodule

// File: tb/tb_riscvsys_evmon.sv
// Bench for riscvsys_evmon: directed scenarios plus randomized launches checked
// against an instruction-level model of what the monitor should report.
module tb_riscvsys_evmon;
   import riscvsys_pkg::*;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst_n;
   ev_vec_t         flags;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] npc;
   logic            dbg;
   wire  [NUM_EV-1:0] ev;
   wire             ev_valid;
   wire  [XLEN-1:0] ev_pc;
   wire  [XLEN-1:0] ev_next_pc;

   int checks;
   int errors;

   // Reference model: what the monitor reported for the most recent cycle
   ev_vec_t         m_ev;
   logic            m_valid;
   logic [XLEN-1:0] m_pc;
   logic [XLEN-1:0] m_npc;

   riscvsys_evmon #(.XLEN(XLEN)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_instr_lui(flags[0]), .i_instr_auipc(flags[1]), .i_instr_jal(flags[2]), .i_instr_jalr(flags[3]),
      .i_instr_beq(flags[4]), .i_instr_bne(flags[5]), .i_instr_blt(flags[6]), .i_instr_bge(flags[7]),
      .i_instr_bltu(flags[8]), .i_instr_bgeu(flags[9]), .i_instr_lb(flags[10]), .i_instr_lh(flags[11]),
      .i_instr_lw(flags[12]), .i_instr_lbu(flags[13]), .i_instr_lhu(flags[14]), .i_instr_sb(flags[15]),
      .i_instr_sh(flags[16]), .i_instr_sw(flags[17]), .i_instr_addi(flags[18]), .i_instr_slti(flags[19]),
      .i_instr_sltiu(flags[20]), .i_instr_xori(flags[21]), .i_instr_ori(flags[22]), .i_instr_andi(flags[23]),
      .i_instr_slli(flags[24]), .i_instr_srli(flags[25]), .i_instr_srai(flags[26]), .i_instr_add(flags[27]),
      .i_instr_sub(flags[28]), .i_instr_sll(flags[29]), .i_instr_slt(flags[30]), .i_instr_sltu(flags[31]),
      .i_instr_xor(flags[32]), .i_instr_srl(flags[33]), .i_instr_sra(flags[34]), .i_instr_or(flags[35]),
      .i_instr_and(flags[36]), .i_instr_rdcycle(flags[37]), .i_instr_rdcycleh(flags[38]),
      .i_instr_rdinstr(flags[39]), .i_instr_rdinstrh(flags[40]), .i_instr_ecall_ebreak(flags[41]),
      .i_instr_getq(flags[42]), .i_instr_setq(flags[43]), .i_instr_retirq(flags[44]),
      .i_instr_maskirq(flags[45]), .i_instr_waitirq(flags[46]), .i_instr_timer(flags[47]),
      .i_instr_trap(flags[48]),
      .i_pc(pc), .i_next_pc(npc), .i_dbg_next(dbg),
      .ev_lui(ev[0]), .ev_auipc(ev[1]), .ev_jal(ev[2]), .ev_jalr(ev[3]),
      .ev_beq(ev[4]), .ev_bne(ev[5]), .ev_blt(ev[6]), .ev_bge(ev[7]),
      .ev_bltu(ev[8]), .ev_bgeu(ev[9]), .ev_lb(ev[10]), .ev_lh(ev[11]),
      .ev_lw(ev[12]), .ev_lbu(ev[13]), .ev_lhu(ev[14]), .ev_sb(ev[15]),
      .ev_sh(ev[16]), .ev_sw(ev[17]), .ev_addi(ev[18]), .ev_slti(ev[19]),
      .ev_sltiu(ev[20]), .ev_xori(ev[21]), .ev_ori(ev[22]), .ev_andi(ev[23]),
      .ev_slli(ev[24]), .ev_srli(ev[25]), .ev_srai(ev[26]), .ev_add(ev[27]),
      .ev_sub(ev[28]), .ev_sll(ev[29]), .ev_slt(ev[30]), .ev_sltu(ev[31]),
      .ev_xor(ev[32]), .ev_srl(ev[33]), .ev_sra(ev[34]), .ev_or(ev[35]),
      .ev_and(ev[36]), .ev_rdcycle(ev[37]), .ev_rdcycleh(ev[38]),
      .ev_rdinstr(ev[39]), .ev_rdinstrh(ev[40]), .ev_ecall_ebreak(ev[41]),
      .ev_getq(ev[42]), .ev_setq(ev[43]), .ev_retirq(ev[44]),
      .ev_maskirq(ev[45]), .ev_waitirq(ev[46]), .ev_timer(ev[47]),
      .ev_trap(ev[48]),
      .ev_valid(ev_valid), .ev_pc(ev_pc), .ev_next_pc(ev_next_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one cycle of core activity and advance the model by what it implies
   task automatic launch(input logic d, input ev_vec_t f, input logic [XLEN-1:0] p, input logic [XLEN-1:0] np);
      @(negedge clk);
      dbg   = d;
      flags = f;
      pc    = p;
      npc   = np;
      if (d) begin
         m_ev    = f;
         m_valid = (f != '0);
         m_pc    = p;
         m_npc   = np;
      end else begin
         m_ev    = '0;
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic compare_model(input string name);
      checks++;
      if (ev !== m_ev || ev_valid !== m_valid || ev_pc !== m_pc || ev_next_pc !== m_npc) begin
         errors++;
         $display("FAIL %s: got ev=%h valid=%b pc=%h npc=%h, want ev=%h valid=%b pc=%h npc=%h",
                  name, ev, ev_valid, ev_pc, ev_next_pc, m_ev, m_valid, m_pc, m_npc);
      end
   endtask

   function automatic ev_vec_t onehot(input int k);
      ev_vec_t v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic test_reset;
      rst_n = 1'b0;
      dbg   = 1'b1;
      flags = onehot(EV_ADD);
      pc    = 32'hDEAD_BEEF;
      npc   = 32'hCAFE_F00D;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ev !== '0 || ev_valid !== 1'b0 || ev_pc !== '0 || ev_next_pc !== '0) begin
         errors++;
         $display("FAIL reset: got ev=%h valid=%b pc=%h npc=%h, want all zero", ev, ev_valid, ev_pc, ev_next_pc);
      end
      @(negedge clk);
      dbg   = 1'b0;
      flags = '0;
      rst_n = 1'b1;
      m_ev = '0; m_valid = 1'b0; m_pc = '0; m_npc = '0;
      @(posedge clk);
      #1;
      compare_model("reset_release");
   endtask

   task automatic test_single;
      launch(1'b1, onehot(EV_LUI), 32'h100, 32'h104);
      checks++;
      if (ev[EV_LUI] !== 1'b1 || ev_valid !== 1'b1 || ev_pc !== 32'h100 || ev_next_pc !== 32'h104) begin
         errors++;
         $display("FAIL single_lui: got lui=%b valid=%b pc=%h npc=%h, want 1 1 100 104",
                  ev[EV_LUI], ev_valid, ev_pc, ev_next_pc);
      end
      launch(1'b0, '0, 32'h0, 32'h0);
      checks++;
      if (ev[EV_LUI] !== 1'b0 || ev_pc !== 32'h100) begin
         errors++;
         $display("FAIL single_after: got lui=%b pc=%h, want 0 100", ev[EV_LUI], ev_pc);
      end
   endtask

   task automatic test_gating;
      ev_vec_t xf;
      for (int c = 0; c < 5; c++) begin
         launch(1'b0, onehot(EV_SW), 32'h2000 + c, 32'h3000 + c);
         compare_model("gating_sw");
      end
      xf = 'x;
      launch(1'b0, xf, 32'h4444, 32'h5555);
      compare_model("gating_x_flags");
   endtask

   task automatic test_sweep;
      for (int k = 0; k < NUM_EV; k++) begin
         launch(1'b1, onehot(k), 32'h1000 + 4 * k, 32'h1004 + 4 * k);
         checks++;
         if (!$onehot(ev) || ev !== onehot(k) || ev_valid !== 1'b1 || ev_pc !== 32'h1000 + 4 * k) begin
            errors++;
            $display("FAIL sweep_%0d: got ev=%h valid=%b pc=%h, want ev=%h valid=1 pc=%h",
                     k, ev, ev_valid, ev_pc, onehot(k), 32'h1000 + 4 * k);
         end
      end
   endtask

   task automatic test_back_to_back;
      int idx [3];
      idx[0] = EV_BEQ; idx[1] = EV_ADDI; idx[2] = EV_TRAP;
      for (int i = 0; i < 3; i++) begin
         launch(1'b1, onehot(idx[i]), 32'h8000 + 4 * i, 32'h8010 + 4 * i);
         checks++;
         if (ev !== onehot(idx[i]) || ev_pc !== 32'h8000 + 4 * i || ev_next_pc !== 32'h8010 + 4 * i) begin
            errors++;
            $display("FAIL b2b_%0d: got ev=%h pc=%h npc=%h, want ev=%h pc=%h npc=%h", i, ev, ev_pc,
                     ev_next_pc, onehot(idx[i]), 32'h8000 + 4 * i, 32'h8010 + 4 * i);
         end
      end
      launch(1'b0, '0, 32'h0, 32'h0);
      compare_model("b2b_idle");
   endtask

   task automatic test_random;
      ev_vec_t f;
      logic    d;
      for (int n = 0; n < 300; n++) begin
         d = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 3))
            0:       f = '0;
            1, 2:    f = onehot($urandom_range(0, NUM_EV - 1));
            default: f = {$urandom, $urandom};
         endcase
         launch(d, f, $urandom, $urandom);
         compare_model("random");
      end
   endtask

   task automatic test_async_reset;
      launch(1'b1, onehot(EV_JAL), 32'hA0, 32'hA4);
      checks++;
      if (ev[EV_JAL] !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: got jal=%b, want 1", ev[EV_JAL]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ev !== '0 || ev_valid !== 1'b0 || ev_pc !== '0) begin
         errors++;
         $display("FAIL async_reset: got ev=%h valid=%b pc=%h, want 0 0 0", ev, ev_valid, ev_pc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dbg   = 1'b0;
      flags = '0;
      m_ev = '0; m_valid = 1'b0; m_pc = '0; m_npc = '0;
      launch(1'b1, onehot(EV_TIMER), 32'hB0, 32'hB4);
      compare_model("after_async_reset");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      dbg = 1'b0; flags = '0; pc = '0; npc = '0;
      m_ev = '0; m_valid = 1'b0; m_pc = '0; m_npc = '0;
      test_reset();
      test_single();
      test_gating();
      test_sweep();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
